// File: rtl/updown_cnt_if.sv
`default_nettype none
// ============================================================================
// Module   : updown_cnt_if
// Purpose  : Control/status bundle for updown_cnt_param.
//            master : drives load/in/en/dir/max/ovf_clr, observes out/tc/wrap_p/ovf
//            slave  : the counter itself
// Ports    : load, in[WIDTH], en, dir, max[WIDTH], ovf_clr  (master -> slave)
//            out[WIDTH], tc, wrap_p, ovf                  (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface updown_cnt_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] in;
  logic             en;
  logic             dir;
  logic [WIDTH-1:0] max;
  logic             ovf_clr;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap_p;
  logic             ovf;

  modport master (
    output load, in, en, dir, max, ovf_clr,
    input  out, tc, wrap_p, ovf
  );

  modport slave (
    input  load, in, en, dir, max, ovf_clr,
    output out, tc, wrap_p, ovf
  );
endinterface
`default_nettype wire

// File: rtl/updown_cnt_param.sv
`default_nettype none
// ============================================================================
// Module   : updown_cnt_param
// Purpose  : Parametrised up/down counter with parallel load, runtime upper
//            limit, wrap or saturate behaviour at the limits, terminal-count
//            flag, one-cycle limit-event pulse and sticky overflow flag.
// Params   : WIDTH    - counter / limit width (>= 2)
//            MODE_SAT - 0: wrap at limits, 1: hold at limits
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous reset, active-low
//            bus  - updown_cnt_if slave modport (load/in/en/dir/max/ovf_clr
//                   in, out/tc/wrap_p/ovf out)
// Revision : 1.0 - initial release
// ============================================================================
module updown_cnt_param #(
  parameter int WIDTH    = 8,
  parameter bit MODE_SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  updown_cnt_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  // Registered state
  logic [WIDTH-1:0] r_out;
  logic             r_wrap_p;
  logic             r_ovf;

  // Combinational next-state
  logic [WIDTH-1:0] w_next;
  logic             w_event;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_above_max;

  assign w_at_max    = (r_out == bus.max);
  assign w_at_zero   = (r_out == c_zero);
  // max may be lowered below the current value at runtime
  assign w_above_max = (r_out > bus.max);

  always_comb begin
    w_next  = r_out;
    w_event = 1'b0;
    if (bus.load) begin
      // Loads are clamped into range and never count as an event
      w_next = (bus.in > bus.max) ? bus.max : bus.in;
    end else if (bus.en) begin
      if (w_above_max) begin
        // Pull back into range regardless of direction
        w_next  = bus.max;
        w_event = 1'b1;
      end else if (bus.dir) begin
        if (w_at_max) begin
          w_event = 1'b1;
          w_next  = MODE_SAT ? bus.max : c_zero;
        end else begin
          w_next = r_out + c_one;
        end
      end else begin
        if (w_at_zero) begin
          w_event = 1'b1;
          w_next  = MODE_SAT ? c_zero : bus.max;
        end else begin
          w_next = r_out - c_one;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out    <= c_zero;
      r_wrap_p <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_out    <= w_next;
      r_wrap_p <= w_event;
      // A new event outranks a clear on the same edge
      if (w_event) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.out    = r_out;
  assign bus.wrap_p = r_wrap_p;
  assign bus.ovf    = r_ovf;
  // Flags that the next enabled count in the current direction hits a limit
  assign bus.tc     = (bus.dir & w_at_max) | (~bus.dir & w_at_zero);

endmodule
`default_nettype wire
